// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of device_mux, one transaction at a time,
// with a watchdog that ends unacknowledged transactions with an error pulse.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_write,
    input  logic              m0_uds,
    input  logic              m0_lds,
    input  logic              m0_rw,
    output logic [DATA_W-1:0] m0_read,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_write,
    input  logic              m1_uds,
    input  logic              m1_lds,
    input  logic              m1_rw,
    output logic [DATA_W-1:0] m1_read,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_write,
    output logic              s_uds,
    output logic              s_lds,
    output logic              s_rw,
    input  logic [DATA_W-1:0] s_read,
    input  logic              s_ack,
    output logic [1:0]        grant
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_owner_q, last_owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy, tmo, done, err;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        tmo          = cnt_q == CW'(TIMEOUT - 1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_req || m1_req) begin
                    state_d = BUSY;
                    owner_d = (m0_req && m1_req) ? ~last_owner_q : m1_req;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (s_ack) begin
                    last_owner_d = owner_q;
                    state_d      = RELEASE;
                end else if (tmo) begin
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by reset so a reset cycle never leaks an ack or a driven bus.
    always_comb begin
        busy    = (state_q == BUSY) && !reset;
        done    = busy && (s_ack || tmo);
        err     = busy && !s_ack && tmo;
        rdata   = s_ack ? s_read : {DATA_W{1'b1}};
        grant   = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        s_addr  = busy ? (owner_q ? m1_addr : m0_addr) : '0;
        s_write = busy ? (owner_q ? m1_write : m0_write) : '0;
        s_uds   = busy && (owner_q ? m1_uds : m0_uds);
        s_lds   = busy && (owner_q ? m1_lds : m0_lds);
        s_rw    = busy ? (owner_q ? m1_rw : m0_rw) : 1'b1;
        m0_ack  = done && !owner_q;
        m1_ack  = done && owner_q;
        m0_err  = err && !owner_q;
        m1_err  = err && owner_q;
        m0_read = m0_ack ? rdata : '0;
        m1_read = m1_ack ? rdata : '0;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table plus hand sequences for timeout, timeout/ack race and reset.
module tb_bus_arbiter;
    typedef struct packed {
        logic        rs;
        logic        r0;
        logic        r1;
        logic        sa;
        logic [15:0] sr;
        logic [1:0]  g;
        logic        a0;
        logic        a1;
        logic        e0;
        logic        e1;
        logic [15:0] d0;
        logic [15:0] d1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = 32'h0000_0100, m1_addr = 32'h0000_0200;
    logic [15:0] m0_write = 16'h1234, m1_write = 16'hBEEF;
    logic        m0_uds = 1'b1, m0_lds = 1'b1, m0_rw = 1'b1;
    logic        m1_uds = 1'b1, m1_lds = 1'b0, m1_rw = 1'b0;
    logic [15:0] m0_read, m1_read;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_addr;
    logic [15:0] s_write;
    logic        s_uds, s_lds, s_rw;
    logic [15:0] s_read = 16'h0;
    logic        s_ack = 1'b0;
    logic [1:0]  grant;
    int          tests = 0, fails = 0, step = 0;
    vec_t        tbl[$];

    bus_arbiter #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_uds(m0_uds),
        .m0_lds(m0_lds), .m0_rw(m0_rw), .m0_read(m0_read), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_uds(m1_uds),
        .m1_lds(m1_lds), .m1_rw(m1_rw), .m1_read(m1_read), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_addr(s_addr), .s_write(s_write), .s_uds(s_uds), .s_lds(s_lds), .s_rw(s_rw),
        .s_read(s_read), .s_ack(s_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r0, r1, sa, input logic [15:0] sr,
                               input logic [1:0] g, input logic a0, a1, e0, e1,
                               input logic [15:0] d0, d1);
        vec_t t;
        t = '{rs: 1'b0, r0: r0, r1: r1, sa: sa, sr: sr, g: g, a0: a0, a1: a1,
              e0: e0, e1: e1, d0: d0, d1: d1};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        reset  = t.rs;
        m0_req = t.r0;
        m1_req = t.r1;
        s_ack  = t.sa;
        s_read = t.sr;
        #1;
        chk("grant", {30'd0, grant}, {30'd0, t.g});
        chk("m0_ack", {31'd0, m0_ack}, {31'd0, t.a0});
        chk("m1_ack", {31'd0, m1_ack}, {31'd0, t.a1});
        chk("m0_err", {31'd0, m0_err}, {31'd0, t.e0});
        chk("m1_err", {31'd0, m1_err}, {31'd0, t.e1});
        chk("m0_read", {16'd0, m0_read}, {16'd0, t.d0});
        chk("m1_read", {16'd0, m1_read}, {16'd0, t.d1});
        chk("s_addr", s_addr, t.g == 2'b01 ? m0_addr : t.g == 2'b10 ? m1_addr : 32'd0);
        chk("s_write", {16'd0, s_write},
            {16'd0, t.g == 2'b01 ? m0_write : t.g == 2'b10 ? m1_write : 16'd0});
        chk("s_uds", {31'd0, s_uds}, {31'd0, t.g == 2'b01 ? m0_uds : t.g == 2'b10 ? m1_uds : 1'b0});
        chk("s_lds", {31'd0, s_lds}, {31'd0, t.g == 2'b01 ? m0_lds : t.g == 2'b10 ? m1_lds : 1'b0});
        chk("s_rw", {31'd0, s_rw}, {31'd0, t.g == 2'b01 ? m0_rw : t.g == 2'b10 ? m1_rw : 1'b1});
        step++;
    endtask

    initial begin
        vec_t r;
        r = v(0, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0);
        r.rs = 1'b1;
        // ties after reset alternate 0,1,0,1
        tbl.push_back(v(1, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 1, 16'hAAAA, 2'b01, 1, 0, 0, 0, 16'hAAAA, 16'h0000));
        tbl.push_back(v(0, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 1, 1, 16'hBBBB, 2'b10, 0, 1, 0, 0, 16'h0000, 16'hBBBB));
        tbl.push_back(v(1, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 1, 16'h1111, 2'b01, 1, 0, 0, 0, 16'h1111, 16'h0000));
        tbl.push_back(v(0, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 1, 16'h2222, 2'b10, 0, 1, 0, 0, 16'h0000, 16'h2222));
        tbl.push_back(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        // m0 read acked 3 cycles after bus driven; m1 arrives mid-BUSY and stalls
        tbl.push_back(v(1, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 0, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(1, 1, 1, 16'h4E71, 2'b01, 1, 0, 0, 0, 16'h4E71, 16'h0000));
        tbl.push_back(v(0, 1, 1, 16'h9999, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 1, 1, 16'h9999, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 1, 1, 16'h5555, 2'b10, 0, 1, 0, 0, 16'h0000, 16'h5555));
        tbl.push_back(v(0, 0, 1, 16'h9999, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 0, 1, 16'h9999, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        // owner drops req before the slave acks; ack still delivered
        tbl.push_back(v(1, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 0, 1, 16'h7777, 2'b01, 1, 0, 0, 0, 16'h7777, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));

        apply(r);
        apply(r);
        foreach (tbl[i]) apply(tbl[i]);

        // m1 write with no slave ack: error in the 8th BUSY cycle
        apply(v(0, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        for (int i = 0; i < 7; i++)
            apply(v(0, 1, 0, 16'h0000, 2'b10, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(0, 1, 0, 16'h0000, 2'b10, 0, 1, 0, 1, 16'h0000, 16'hFFFF));
        apply(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(0, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(0, 1, 1, 16'h600D, 2'b10, 0, 1, 0, 0, 16'h0000, 16'h600D));
        apply(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));

        // s_ack lands on the timeout cycle: normal ack, no error
        apply(v(1, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        for (int i = 0; i < 7; i++)
            apply(v(1, 0, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(1, 0, 1, 16'hC0DE, 2'b01, 1, 0, 0, 0, 16'hC0DE, 16'h0000));
        apply(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));

        // reset in the 2nd BUSY cycle, then the re-issued request completes
        apply(v(1, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(1, 0, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000));
        r = v(1, 0, 1, 16'hDEAD, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
        r.rs = 1'b1;
        apply(r);
        apply(v(1, 0, 1, 16'hDEAD, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));
        apply(v(1, 0, 1, 16'hABCD, 2'b01, 1, 0, 0, 0, 16'hABCD, 16'h0000));
        apply(v(0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
